// File: rtl/v_load_wb.sv
// Load writeback: captures a 512-bit load result and writes it to the VRF one 128-bit register per grant.
// Latency: l_done at edge n -> vrf_we with beat 0 visible in cycle n+1; one beat per granted cycle, no bubbles.
// Backpressure: beats hold stable while vrf_wr_gnt is low; l_done while a group is in flight is dropped with overrun_err.
//
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   l_done, l_data_in          load-complete strobe and 512-bit load result
//   lmul, vd                   group size encoding and base register, sampled with an accepted l_done
//   vrf_wr_gnt                 write-port grant for the presented beat
//   vrf_we/vrf_waddr/vrf_wdata write request, register address, register data
//   busy, wb_done, overrun_err group in flight, group-finished pulse, dropped-load pulse
module v_load_wb #(
  parameter int VLEN     = 128,
  parameter int MAX_REGS = 4,
  parameter int VREG_AW  = 5
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     l_done,
  input  logic [VLEN*MAX_REGS-1:0] l_data_in,
  input  logic [2:0]               lmul,
  input  logic [VREG_AW-1:0]       vd,
  input  logic                     vrf_wr_gnt,
  output logic                     vrf_we,
  output logic [VREG_AW-1:0]       vrf_waddr,
  output logic [VLEN-1:0]          vrf_wdata,
  output logic                     busy,
  output logic                     wb_done,
  output logic                     overrun_err
);

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

  state_t                     state_q, state_d;
  logic [VLEN*MAX_REGS-1:0]   buf_q, buf_d;
  logic [VREG_AW-1:0]         vd_q, vd_d;
  logic [2:0]                 count_q, count_d;
  logic [1:0]                 k_q, k_d;
  logic                       wb_done_q, wb_done_d;
  logic                       overrun_q, overrun_d;

  logic [2:0] lmul_count;
  logic       beat_done;
  logic       last_beat;
  logic       final_done;
  logic       accept;

  // Register count for the group; reserved encodings are treated as a single register.
  always_comb begin
    lmul_count = 3'd1;
    case (lmul)
      3'b001:  lmul_count = 3'd2;
      3'b010:  lmul_count = 3'd4;
      default: lmul_count = 3'd1;
    endcase
  end

  assign beat_done  = (state_q == WRITE) && vrf_wr_gnt;
  assign last_beat  = ({1'b0, k_q} == (count_q - 3'd1));
  assign final_done = beat_done && last_beat;
  // A new load fits only when idle or when the current group retires on this very edge.
  assign accept     = l_done && ((state_q == IDLE) || final_done);

  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    vd_d      = vd_q;
    count_d   = count_q;
    k_d       = k_q;
    wb_done_d = final_done;
    overrun_d = l_done && !accept;

    if (accept) begin
      state_d = WRITE;
      buf_d   = l_data_in;
      vd_d    = vd;
      count_d = lmul_count;
      k_d     = 2'd0;
    end else if (final_done) begin
      state_d = IDLE;
      k_d     = 2'd0;
    end else if (beat_done) begin
      k_d = k_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      vd_q      <= '0;
      count_q   <= '0;
      k_q       <= '0;
      wb_done_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      vd_q      <= vd_d;
      count_q   <= count_d;
      k_q       <= k_d;
      wb_done_q <= wb_done_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs decode directly from flops; address and data are forced to zero outside WRITE.
  always_comb begin
    vrf_we    = (state_q == WRITE);
    vrf_waddr = '0;
    vrf_wdata = '0;
    if (state_q == WRITE) begin
      vrf_waddr = vd_q + VREG_AW'(k_q);   // wraps modulo the register file size
      vrf_wdata = buf_q[int'(k_q)*VLEN +: VLEN];
    end
  end

  assign busy        = (state_q == WRITE);
  assign wb_done     = wb_done_q;
  assign overrun_err = overrun_q;

endmodule
